// File: rtl/panda_risc_v_ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: issues sequential PC requests on the
// instruction bus and limits them to MAX_OUTSTANDING credits. Each in-order
// response is paired with its PC, and responses left stale by a flush or
// system reset are dropped. Accepted instructions go to the fetch-stage
// register as a valid/ready stream with no added latency.
module panda_risc_v_ifu_fetch_ctrl #(
    parameter int          IBUS_TID_WIDTH  = 8,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RST_PC          = 32'h0000_0000,
    parameter int          SIM_DELAY       = 1
)(
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic                                       sys_reset_req,
    input  logic                                       flush_req,
    input  logic [31:0]                                flush_addr,
    output logic [31:0]                                m_ibus_req_addr,
    output logic [IBUS_TID_WIDTH-1:0]                  m_ibus_req_tid,
    output logic                                       m_ibus_req_valid,
    input  logic                                       m_ibus_req_ready,
    input  logic [31:0]                                s_ibus_resp_rdata,
    input  logic [1:0]                                 s_ibus_resp_err,
    input  logic [IBUS_TID_WIDTH-1:0]                  s_ibus_resp_tid,
    input  logic                                       s_ibus_resp_valid,
    output logic                                       s_ibus_resp_ready,
    output logic [31:0]                                m_fetch_inst,
    output logic [31:0]                                m_fetch_pc,
    output logic [1:0]                                 m_fetch_err,
    output logic [IBUS_TID_WIDTH-1:0]                  m_fetch_id,
    output logic                                       m_fetch_is_first_inst_after_rst,
    output logic                                       m_fetch_valid,
    input  logic                                       m_fetch_ready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       in_flight_cnt,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       discard_cnt
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    // Registers update without a modelled delay; the parameter is only
    // accepted so existing instantiations keep elaborating.
    logic unused_sim_delay;
    assign unused_sim_delay = (SIM_DELAY != 0);

    logic [31:0]               pc_reg, pc_next;
    logic [IBUS_TID_WIDTH-1:0] tid_reg, tid_next;
    logic [CNT_W-1:0]          in_flight_reg, in_flight_next;
    logic [CNT_W-1:0]          discard_reg, discard_next;
    logic                      first_reg, first_next;
    logic [PTR_W-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]          rd_ptr_reg, rd_ptr_next;
    logic [31:0]               pc_fifo [MAX_OUTSTANDING];

    logic on_flush;
    logic discarding;
    logic req_fire;
    logic resp_fire;
    logic pop;

    // Handshake qualification: flush blocks new requests, stale responses
    // are always drained, and a response with nothing in flight is ignored.
    always_comb begin
        on_flush          = sys_reset_req | flush_req;
        discarding        = (discard_reg != '0);
        m_ibus_req_valid  = aresetn & ~on_flush & (in_flight_reg < MAX_CNT);
        req_fire          = m_ibus_req_valid & m_ibus_req_ready;
        s_ibus_resp_ready = on_flush | discarding | m_fetch_ready;
        m_fetch_valid     = aresetn & s_ibus_resp_valid & ~on_flush & ~discarding;
        resp_fire         = s_ibus_resp_valid & s_ibus_resp_ready & (in_flight_reg != '0);
        pop               = resp_fire & ~on_flush & ~discarding;
    end

    // Request and fetch payloads: requests come straight from the PC/TID
    // counters, fetch output bypasses the response and takes the FIFO head.
    always_comb begin
        m_ibus_req_addr                 = pc_reg;
        m_ibus_req_tid                  = tid_reg;
        m_fetch_inst                    = s_ibus_resp_rdata;
        m_fetch_err                     = s_ibus_resp_err;
        m_fetch_id                      = s_ibus_resp_tid;
        m_fetch_pc                      = pc_fifo[rd_ptr_reg];
        m_fetch_is_first_inst_after_rst = first_reg;
        in_flight_cnt                   = in_flight_reg;
        discard_cnt                     = discard_reg;
    end

    // Next-state: a flush converts everything still in flight (minus the
    // response dropped this cycle) into responses to discard.
    always_comb begin
        pc_next        = pc_reg;
        tid_next       = tid_reg;
        first_next     = first_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        in_flight_next = in_flight_reg + CNT_W'(req_fire) - CNT_W'(resp_fire);
        discard_next   = discard_reg;

        if (on_flush) begin
            discard_next = in_flight_reg - CNT_W'(resp_fire);
            wr_ptr_next  = '0;
            rd_ptr_next  = '0;
            if (sys_reset_req) begin
                pc_next    = RST_PC;
                tid_next   = '0;
                first_next = 1'b1;
            end else begin
                pc_next    = flush_addr;
            end
        end else begin
            if (resp_fire && discarding)
                discard_next = discard_reg - 1'b1;
            if (req_fire) begin
                pc_next     = pc_reg + 32'd4;
                tid_next    = tid_reg + 1'b1;
                wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                first_next  = 1'b0;
                rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pc_reg        <= RST_PC;
            tid_reg       <= '0;
            in_flight_reg <= '0;
            discard_reg   <= '0;
            first_reg     <= 1'b1;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            pc_reg        <= pc_next;
            tid_reg       <= tid_next;
            in_flight_reg <= in_flight_next;
            discard_reg   <= discard_next;
            first_reg     <= first_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
        end
    end

    // PC FIFO storage: one register per slot, written with the issued PC.
    // Occupancy is tracked by the pointers, so the data needs no reset.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_pc_fifo
            logic [31:0] entry_reg;

            // Capture the request PC when this slot is the write target.
            always_ff @(posedge aclk) begin
                if (req_fire && (wr_ptr_reg == PTR_W'(gi)))
                    entry_reg <= pc_reg;
            end

            assign pc_fifo[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_panda_risc_v_ifu_fetch_ctrl.sv
// Bench for the fetch sequencer: a queue-based model of the in-flight
// requests (each tagged stale or live) predicts every handshake and payload,
// while a simple in-order bus model answers requests with random data.
module tb_panda_risc_v_ifu_fetch_ctrl;

    localparam int          TW    = 2;
    localparam int          MAXO  = 4;
    localparam logic [31:0] RSTPC = 32'h0000_0000;

    logic          aclk;
    logic          aresetn;
    logic          sys_reset_req;
    logic          flush_req;
    logic [31:0]   flush_addr;
    logic [31:0]   m_ibus_req_addr;
    logic [TW-1:0] m_ibus_req_tid;
    logic          m_ibus_req_valid;
    logic          m_ibus_req_ready;
    logic [31:0]   s_ibus_resp_rdata;
    logic [1:0]    s_ibus_resp_err;
    logic [TW-1:0] s_ibus_resp_tid;
    logic          s_ibus_resp_valid;
    logic          s_ibus_resp_ready;
    logic [31:0]   m_fetch_inst;
    logic [31:0]   m_fetch_pc;
    logic [1:0]    m_fetch_err;
    logic [TW-1:0] m_fetch_id;
    logic          m_fetch_is_first_inst_after_rst;
    logic          m_fetch_valid;
    logic          m_fetch_ready;
    logic [2:0]    in_flight_cnt;
    logic [2:0]    discard_cnt;

    panda_risc_v_ifu_fetch_ctrl #(
        .IBUS_TID_WIDTH (TW),
        .MAX_OUTSTANDING(MAXO),
        .RST_PC         (RSTPC),
        .SIM_DELAY      (1)
    ) dut (
        .aclk                           (aclk),
        .aresetn                        (aresetn),
        .sys_reset_req                  (sys_reset_req),
        .flush_req                      (flush_req),
        .flush_addr                     (flush_addr),
        .m_ibus_req_addr                (m_ibus_req_addr),
        .m_ibus_req_tid                 (m_ibus_req_tid),
        .m_ibus_req_valid               (m_ibus_req_valid),
        .m_ibus_req_ready               (m_ibus_req_ready),
        .s_ibus_resp_rdata              (s_ibus_resp_rdata),
        .s_ibus_resp_err                (s_ibus_resp_err),
        .s_ibus_resp_tid                (s_ibus_resp_tid),
        .s_ibus_resp_valid              (s_ibus_resp_valid),
        .s_ibus_resp_ready              (s_ibus_resp_ready),
        .m_fetch_inst                   (m_fetch_inst),
        .m_fetch_pc                     (m_fetch_pc),
        .m_fetch_err                    (m_fetch_err),
        .m_fetch_id                     (m_fetch_id),
        .m_fetch_is_first_inst_after_rst(m_fetch_is_first_inst_after_rst),
        .m_fetch_valid                  (m_fetch_valid),
        .m_fetch_ready                  (m_fetch_ready),
        .in_flight_cnt                  (in_flight_cnt),
        .discard_cnt                    (discard_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: one entry per in-flight request, oldest first.
    typedef struct {
        logic [31:0]   pc;
        logic [TW-1:0] tid;
        bit            stale;
    } ent_t;

    // Bus model: requests it has accepted and will answer in order.
    typedef struct {
        logic [TW-1:0] tid;
        logic [31:0]   data;
        logic [1:0]    err;
    } bus_t;

    ent_t          mq[$];
    bus_t          bq[$];
    logic [31:0]   log_addr[$];
    logic [TW-1:0] log_tid[$];
    logic [31:0]   m_pc;
    logic [TW-1:0] m_tid;
    bit            m_first;
    bit            resp_en;
    int            vectors;
    int            errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive the bus, check every output against the model just
    // before the edge, then advance the model with the handshakes that fired.
    task automatic do_cycle();
        bit            flush;
        bit            exp_req_v;
        bit            exp_resp_r;
        bit            exp_fv;
        bit            rf;
        bit            sf;
        int            stale;
        logic [31:0]   obs_addr;
        logic [TW-1:0] obs_tid;
        ent_t          e;
        bus_t          b;

        if (resp_en && bq.size() > 0) begin
            s_ibus_resp_valid = 1'b1;
            s_ibus_resp_rdata = bq[0].data;
            s_ibus_resp_err   = bq[0].err;
            s_ibus_resp_tid   = bq[0].tid;
        end else begin
            s_ibus_resp_valid = 1'b0;
            s_ibus_resp_rdata = $urandom;
            s_ibus_resp_err   = 2'(($urandom_range(0, 3)));
            s_ibus_resp_tid   = '0;
        end
        #1;

        flush = sys_reset_req || flush_req;
        stale = 0;
        foreach (mq[i]) if (mq[i].stale) stale++;

        exp_req_v = !flush && (mq.size() < MAXO);
        chk("req_valid", 32'(m_ibus_req_valid), 32'(exp_req_v));
        if (exp_req_v) begin
            chk("req_addr", m_ibus_req_addr, m_pc);
            chk("req_tid", 32'(m_ibus_req_tid), 32'(m_tid));
        end
        exp_resp_r = flush || (stale > 0) || m_fetch_ready;
        chk("resp_ready", 32'(s_ibus_resp_ready), 32'(exp_resp_r));
        exp_fv = s_ibus_resp_valid && !flush && (stale == 0);
        chk("fetch_valid", 32'(m_fetch_valid), 32'(exp_fv));
        if (exp_fv) begin
            chk("fetch_inst", m_fetch_inst, bq[0].data);
            chk("fetch_err", 32'(m_fetch_err), 32'(bq[0].err));
            chk("fetch_id", 32'(m_fetch_id), 32'(mq[0].tid));
            chk("fetch_pc", m_fetch_pc, mq[0].pc);
            chk("fetch_first", 32'(m_fetch_is_first_inst_after_rst), 32'(m_first));
        end
        chk("in_flight", 32'(in_flight_cnt), 32'(mq.size()));
        chk("discard", 32'(discard_cnt), 32'(stale));

        rf       = exp_req_v && m_ibus_req_ready;
        sf       = s_ibus_resp_valid && exp_resp_r;
        obs_addr = m_ibus_req_addr;
        obs_tid  = m_ibus_req_tid;

        @(posedge aclk);
        if (sf) begin
            e = mq.pop_front();
            bq.delete(0);
            if (!e.stale && !flush) m_first = 1'b0;
        end
        if (flush) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            if (sys_reset_req) begin
                m_pc    = RSTPC;
                m_tid   = '0;
                m_first = 1'b1;
            end else begin
                m_pc    = flush_addr;
            end
        end
        if (rf) begin
            e.pc = m_pc; e.tid = m_tid; e.stale = 1'b0;
            mq.push_back(e);
            b.tid = obs_tid; b.data = $urandom; b.err = 2'($urandom_range(0, 3));
            bq.push_back(b);
            log_addr.push_back(obs_addr);
            log_tid.push_back(obs_tid);
            m_pc  = m_pc + 32'd4;
            m_tid = m_tid + 1'b1;
        end
        @(negedge aclk);
        #1;
    endtask

    task automatic drain();
        m_ibus_req_ready = 1'b0;
        m_fetch_ready    = 1'b1;
        resp_en          = 1'b1;
        for (int k = 0; k < 40 && mq.size() != 0; k++) do_cycle();
        chk("drain_in_flight", 32'(in_flight_cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_a [6];
        logic [31:0] exp_t [6];
        vectors = 0;
        errors  = 0;
        m_pc    = RSTPC;
        m_tid   = '0;
        m_first = 1'b1;
        resp_en = 1'b0;

        // Reset: outputs must stay quiet even with a response presented.
        aresetn           = 1'b0;
        sys_reset_req     = 1'b0;
        flush_req         = 1'b0;
        flush_addr        = '0;
        m_ibus_req_ready  = 1'b1;
        m_fetch_ready     = 1'b1;
        s_ibus_resp_valid = 1'b1;
        s_ibus_resp_rdata = 32'hDEAD_BEEF;
        s_ibus_resp_err   = 2'b00;
        s_ibus_resp_tid   = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #1;
        chk("rst_req_valid", 32'(m_ibus_req_valid), 32'd0);
        chk("rst_fetch_valid", 32'(m_fetch_valid), 32'd0);
        aresetn           = 1'b1;
        s_ibus_resp_valid = 1'b0;
        #1;
        chk("rst_in_flight", 32'(in_flight_cnt), 32'd0);
        chk("rst_discard", 32'(discard_cnt), 32'd0);
        chk("rst_first", 32'(m_fetch_is_first_inst_after_rst), 32'd1);
        chk("rst_addr", m_ibus_req_addr, RSTPC);

        // Plan 1: streaming with a one-cycle bus.
        resp_en = 1'b1;
        repeat (8) do_cycle();
        chk("p1_addr0", log_addr[0], 32'h0);
        chk("p1_addr2", log_addr[2], 32'h8);
        chk("p1_tid2", 32'(log_tid[2]), 32'd2);

        // Plan 2: fetch stall fills the credits, then releases.
        drain();
        m_ibus_req_ready = 1'b1;
        m_fetch_ready    = 1'b0;
        repeat (8) do_cycle();
        chk("p2_in_flight", 32'(in_flight_cnt), 32'd4);
        chk("p2_req_valid", 32'(m_ibus_req_valid), 32'd0);
        m_fetch_ready = 1'b1;
        repeat (6) do_cycle();

        // Plan 3: flush with three requests outstanding.
        drain();
        resp_en          = 1'b0;
        m_ibus_req_ready = 1'b1;
        repeat (3) do_cycle();
        flush_req  = 1'b1;
        flush_addr = 32'h0000_0100;
        do_cycle();
        flush_req = 1'b0;
        chk("p3_discard", 32'(discard_cnt), 32'd3);
        chk("p3_addr", m_ibus_req_addr, 32'h0000_0100);
        resp_en = 1'b1;
        repeat (10) do_cycle();

        // Plan 4: flush coinciding with a response fire, two in flight.
        drain();
        resp_en          = 1'b0;
        m_ibus_req_ready = 1'b1;
        repeat (2) do_cycle();
        resp_en    = 1'b1;
        flush_req  = 1'b1;
        flush_addr = 32'h0000_0200;
        do_cycle();
        flush_req = 1'b0;
        resp_en   = 1'b0;
        chk("p4_discard", 32'(discard_cnt), 32'd1);
        chk("p4_in_flight", 32'(in_flight_cnt), 32'd1);
        resp_en = 1'b1;
        repeat (6) do_cycle();

        // Plan 5: system reset in the middle of traffic.
        repeat (3) do_cycle();
        sys_reset_req = 1'b1;
        do_cycle();
        sys_reset_req = 1'b0;
        chk("p5_addr", m_ibus_req_addr, RSTPC);
        chk("p5_tid", 32'(m_ibus_req_tid), 32'd0);
        chk("p5_first", 32'(m_fetch_is_first_inst_after_rst), 32'd1);
        repeat (8) do_cycle();

        // Plan 6: narrow TID wrap and 32-bit PC wrap.
        drain();
        m_ibus_req_ready = 1'b1;
        sys_reset_req    = 1'b1;
        do_cycle();
        sys_reset_req = 1'b0;
        flush_req     = 1'b1;
        flush_addr    = 32'hFFFF_FFF4;
        do_cycle();
        flush_req = 1'b0;
        log_addr.delete();
        log_tid.delete();
        repeat (9) do_cycle();
        exp_a = '{32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        exp_t = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        chk("p6_count", 32'(log_addr.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            chk("p6_addr", log_addr[i], exp_a[i]);
            chk("p6_tid", 32'(log_tid[i]), exp_t[i]);
        end

        // Randomised traffic with occasional flushes and system resets.
        for (int n = 0; n < 500; n++) begin
            m_ibus_req_ready = ($urandom_range(0, 3) != 0);
            m_fetch_ready    = ($urandom_range(0, 3) != 0);
            resp_en          = ($urandom_range(0, 4) != 0);
            flush_req        = ($urandom_range(0, 24) == 0);
            sys_reset_req    = ($urandom_range(0, 59) == 0);
            flush_addr       = {$urandom, 2'b00} >> 2 << 2;
            do_cycle();
        end
        flush_req     = 1'b0;
        sys_reset_req = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
